// File: rtl/reg_q.sv
// Multiplier (Q) register of the radix-4 Booth datapath: q[7:0] operand plus
// Booth extra bit q[-1], with operand load, Booth-bit clear and 2-bit right shift.
module reg_q (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0,
    input  logic        c1,
    input  logic        c5,
    input  logic [1:0]  shift_inc,
    input  logic [7:0]  inbus,
    output logic [7:-1] q
);

    localparam int unsigned OP_W    = 8;
    localparam int unsigned SHIFT_W = 2;

    logic [OP_W-1:0] opnd_nxt_c;
    logic            booth_nxt_c;

    // Load beats shift on the operand bits; Booth bit clear beats shift capture.
    always_comb begin
        opnd_nxt_c  = q[7:0];
        booth_nxt_c = q[-1];
        if (c1) begin
            opnd_nxt_c = inbus;
        end else if (c5) begin
            opnd_nxt_c = {shift_inc, q[OP_W-1:SHIFT_W]};
        end
        if (c0) begin
            booth_nxt_c = 1'b0;
        end else if (c5 && !c1) begin
            booth_nxt_c = q[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= {opnd_nxt_c, booth_nxt_c};
        end
    end

endmodule

// File: tb/tb_reg_q.sv
// Randomized self-checking bench for reg_q against a 9-bit word model
// (operand in bits 8:1, Booth bit in bit 0).
module tb_reg_q;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0, c1, c5;
    logic [1:0]  shift_inc;
    logic [7:0]  inbus;
    logic [7:-1] q;

    logic [8:0]  exp_q;
    logic [8:0]  q_word;
    logic        chk_en;
    int          n_pass;
    int          n_total;

    reg_q dut (
        .clk       (clk),
        .reset     (reset),
        .c0        (c0),
        .c1        (c1),
        .c5        (c5),
        .shift_inc (shift_inc),
        .inbus     (inbus),
        .q         (q)
    );

    always #5 clk = ~clk;

    assign q_word = q;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got q=%03h (opnd=%02h booth=%0b) want %03h (opnd=%02h booth=%0b) at %0t",
                      name, got, got[8:1], got[0], want, want[8:1], want[0], $time);
    endtask

    // Next value of the 9-bit word from the behavioural rules.
    function automatic logic [8:0] model_next(input logic [8:0] w, input logic rst,
                                              input logic s0, input logic s1, input logic s5,
                                              input logic [1:0] si, input logic [7:0] ib);
        logic [8:0] shifted;
        logic [7:0] hi;
        logic       b;
        if (!rst) return 9'h000;
        shifted = (w >> 2) | (9'(si) << 7);
        hi = s1 ? ib : (s5 ? shifted[8:1] : w[8:1]);
        b  = s0 ? 1'b0 : ((s5 && !s1) ? shifted[0] : w[0]);
        return {hi, b};
    endfunction

    task automatic step(input logic s0, input logic s1, input logic s5,
                        input logic [1:0] si, input logic [7:0] ib);
        logic [8:0] nxt;
        c0 = s0; c1 = s1; c5 = s5; shift_inc = si; inbus = ib;
        nxt = model_next(exp_q, reset, s0, s1, s5, si, ib);
        @(posedge clk);
        #1;
        exp_q = nxt;
    endtask

    task automatic async_reset_check(input string name);
        reset = 1'b0;
        #1;
        exp_q = 9'h000;
        check(name, q_word, 9'h000);
    endtask

    // Every-cycle comparison of DUT state against the model.
    always @(negedge clk) begin
        if (chk_en) check("cycle", q_word, exp_q);
    end

    initial begin
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        reset = 1'b0; c0 = 0; c1 = 0; c5 = 0; shift_inc = 0; inbus = 0;
        exp_q = 9'h000;
        #2;
        chk_en = 1'b1;
        check("reset_state", q_word, 9'h000);

        // strobes while reset held have no effect
        step(1, 1, 1, 2'b11, 8'hFF);
        step(0, 0, 1, 2'b10, 8'h55);
        check("strobes_in_reset", q_word, 9'h000);
        reset = 1'b1;

        step(1, 1, 0, 2'b00, 8'hA5);
        check("init_load_A5", q_word, {8'hA5, 1'b0});
        step(0, 0, 1, 2'b11, 8'h00);
        check("shift_inc11", q_word, {8'hE9, 1'b0});
        step(0, 0, 1, 2'b00, 8'hFF);
        check("shift_inc00", q_word, {8'h3A, 1'b0});

        step(1, 1, 0, 2'b00, 8'h06);
        check("load_06", q_word, {8'h06, 1'b0});
        step(0, 0, 1, 2'b00, 8'h00);
        check("booth_capture", q_word, {8'h01, 1'b1});
        step(1, 0, 0, 2'b11, 8'hFF);
        check("booth_clear", q_word, {8'h01, 1'b0});

        step(0, 1, 0, 2'b00, 8'h06);
        step(0, 0, 1, 2'b00, 8'h00);
        check("booth_set_again", q_word, {8'h01, 1'b1});
        step(0, 1, 1, 2'b11, 8'h3C);
        check("load_over_shift", q_word, {8'h3C, 1'b1});

        for (int i = 0; i < 5; i++) step(0, 0, 0, 2'(i), 8'(i * 37 + 1));
        check("hold_5", q_word, {8'h3C, 1'b1});

        // abort mid-multiply, then stay clear until the next load
        step(0, 0, 1, 2'b10, 8'h00);
        async_reset_check("async_reset_mid_shift");
        step(0, 0, 1, 2'b01, 8'h77);
        reset = 1'b1;
        step(0, 0, 0, 2'b11, 8'h99);
        check("after_reset_hold", q_word, 9'h000);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset_check("async_reset_rand");
                step(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
                reset = 1'b1;
            end else begin
                step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
